intra_chroma_mode_decider: RTL and testbench

Chroma 8x8 intra mode-decision stage that sits directly downstream of the chroma SAD stage. It consumes the per-mode SAD triples for the Cb block and then the Cr block of one macroblock. It sums them per mode, selects the minimum-cost chroma prediction mode, and hands the decision to the mode-encode stage over a valid/ready handshake. It also keeps per-mode usage counters for rate-control statistics.

---
 rtl/chroma_pred_pkg.sv | 25 ++
 rtl/intra_chroma_mode_decider_if.sv | 24 ++
 rtl/min3_select.sv | 26 ++
 rtl/intra_chroma_mode_decider.sv | 119 +++++++++++
 tb/tb_intra_chroma_mode_decider.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/chroma_pred_pkg.sv
// Shared types and constants for the chroma intra-prediction mode-decision path.
package chroma_pred_pkg;

  typedef enum logic [1:0] {
    CM_DC    = 2'd0,
    CM_H     = 2'd1,
    CM_V     = 2'd2,
    CM_PLANE = 2'd3
  } chroma_mode_e;

  // Slot order of the incoming SAD triple
  localparam int unsigned SAD_V  = 0;
  localparam int unsigned SAD_H  = 1;
  localparam int unsigned SAD_DC = 2;

  typedef enum logic [1:0] {
    S_CB,
    S_CR,
    S_CMP,
    S_OUT
  } state_e;

  localparam int unsigned SAD_W_DEFAULT = 8;

endpackage

// File: rtl/intra_chroma_mode_decider_if.sv
// SAD-in and decision-out handshakes of the chroma mode decider.
interface intra_chroma_mode_decider_if
  import chroma_pred_pkg::*;
#(
  parameter int unsigned SAD_W = SAD_W_DEFAULT
);
  logic             sad_valid;
  logic             sad_ready;
  logic [SAD_W-1:0] sads [3];
  logic             mode_valid;
  logic             mode_ready;
  logic [1:0]       mode_out;
  logic [SAD_W:0]   best_sad;

  modport slave (
    input  sad_valid, sads, mode_ready,
    output sad_ready, mode_valid, mode_out, best_sad
  );

  modport master (
    output sad_valid, sads, mode_ready,
    input  sad_ready, mode_valid, mode_out, best_sad
  );
endinterface

// File: rtl/min3_select.sv
// Combinational three-way minimum; ties resolve DC over horizontal over vertical.
module min3_select
  import chroma_pred_pkg::*;
#(
  parameter int unsigned W = SAD_W_DEFAULT + 1
) (
  input  logic [W-1:0] v_sad,
  input  logic [W-1:0] h_sad,
  input  logic [W-1:0] dc_sad,
  output chroma_mode_e mode,
  output logic [W-1:0] min_sad
);
  // Strict less-than so a lower-priority mode never displaces an equal one
  always_comb begin
    mode    = CM_DC;
    min_sad = dc_sad;
    if (h_sad < min_sad) begin
      mode    = CM_H;
      min_sad = h_sad;
    end
    if (v_sad < min_sad) begin
      mode    = CM_V;
      min_sad = v_sad;
    end
  end
endmodule

// File: rtl/intra_chroma_mode_decider.sv
// Sums Cb+Cr SADs per mode, picks the cheapest chroma mode and keeps usage counts.
module intra_chroma_mode_decider
  import chroma_pred_pkg::*;
#(
  parameter int unsigned SAD_W = SAD_W_DEFAULT,
  parameter int unsigned CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  intra_chroma_mode_decider_if.slave  bus,
  input  logic                        stat_clear,
  output logic [CNT_W-1:0]            cnt_dc,
  output logic [CNT_W-1:0]            cnt_h,
  output logic [CNT_W-1:0]            cnt_v
);
  localparam int unsigned TW = SAD_W + 1;

  state_e       state_q, state_d;
  logic [TW-1:0] tot_q [3];
  logic [TW-1:0] tot_d [3];
  chroma_mode_e mode_q, mode_d, min_mode;
  logic [TW-1:0] best_q, best_d, min_val;
  logic         valid_q, valid_d;
  logic         inc;
  logic [CNT_W-1:0] cnt_dc_q, cnt_h_q, cnt_v_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  min3_select #(.W(TW)) u_min3 (
    .v_sad   (tot_q[SAD_V]),
    .h_sad   (tot_q[SAD_H]),
    .dc_sad  (tot_q[SAD_DC]),
    .mode    (min_mode),
    .min_sad (min_val)
  );

  always_comb begin
    state_d = state_q;
    tot_d   = tot_q;
    mode_d  = mode_q;
    best_d  = best_q;
    valid_d = valid_q;
    inc     = 1'b0;
    unique case (state_q)
      S_CB: begin
        if (bus.sad_valid) begin
          for (int k = 0; k < 3; k++) tot_d[k] = TW'(bus.sads[k]);
          state_d = S_CR;
        end
      end
      S_CR: begin
        if (bus.sad_valid) begin
          for (int k = 0; k < 3; k++) tot_d[k] = tot_q[k] + TW'(bus.sads[k]);
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        mode_d  = min_mode;
        best_d  = min_val;
        valid_d = 1'b1;
        inc     = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.mode_ready) begin
          valid_d = 1'b0;
          state_d = S_CB;
        end
      end
      default: state_d = S_CB;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_CB;
      for (int k = 0; k < 3; k++) tot_q[k] <= '0;
      mode_q  <= CM_DC;
      best_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tot_q   <= tot_d;
      mode_q  <= mode_d;
      best_q  <= best_d;
      valid_q <= valid_d;
    end
  end

  // Clear has priority over a coincident increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_dc_q <= '0;
      cnt_h_q  <= '0;
      cnt_v_q  <= '0;
    end else if (stat_clear) begin
      cnt_dc_q <= '0;
      cnt_h_q  <= '0;
      cnt_v_q  <= '0;
    end else if (inc) begin
      unique case (min_mode)
        CM_DC:   cnt_dc_q <= sat_inc(cnt_dc_q);
        CM_H:    cnt_h_q  <= sat_inc(cnt_h_q);
        CM_V:    cnt_v_q  <= sat_inc(cnt_v_q);
        default: ;
      endcase
    end
  end

  assign bus.sad_ready  = (state_q == S_CB) || (state_q == S_CR);
  assign bus.mode_valid = valid_q;
  assign bus.mode_out   = mode_q;
  assign bus.best_sad   = best_q;
  assign cnt_dc         = cnt_dc_q;
  assign cnt_h          = cnt_h_q;
  assign cnt_v          = cnt_v_q;
endmodule

// File: tb/tb_intra_chroma_mode_decider.sv
// Directed and randomized pairs checked against a per-mode cost model of the decider.
module tb_intra_chroma_mode_decider;
  import chroma_pred_pkg::*;

  localparam int unsigned SW      = 8;
  localparam int unsigned CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stat_clear = 1'b0;
  logic [CW-1:0] cnt_dc, cnt_h, cnt_v;

  intra_chroma_mode_decider_if #(.SAD_W(SW)) bus ();

  intra_chroma_mode_decider #(.SAD_W(SW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .stat_clear (stat_clear),
    .cnt_dc     (cnt_dc),
    .cnt_h      (cnt_h),
    .cnt_v      (cnt_v)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int exp_cnt [3];  // indexed by mode code: 0 DC, 1 H, 2 V
  int cb [3];       // SAD slots: 0 V, 1 H, 2 DC
  int cr [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "/cnt_dc"}, 32'(cnt_dc), exp_cnt[0]);
    chk({tag, "/cnt_h"},  32'(cnt_h),  exp_cnt[1]);
    chk({tag, "/cnt_v"},  32'(cnt_v),  exp_cnt[2]);
  endtask

  task automatic send_triple(input string tag, input int v, input int h, input int dc);
    int  n;
    bit  acc;
    n   = 0;
    acc = 1'b0;
    bus.sad_valid = 1'b1;
    bus.sads[0]   = v[SW-1:0];
    bus.sads[1]   = h[SW-1:0];
    bus.sads[2]   = dc[SW-1:0];
    while (!acc && n < 20) begin
      acc = bus.sad_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.sad_valid = 1'b0;
    chk({tag, "/accept"}, 32'(acc), 1);
  endtask

  // Model: per-mode totals, cheapest wins, earlier mode in DC,H,V order wins ties
  task automatic run_pair(input string tag, input int hold, input bit clr);
    int tot [3];
    int em, eb;
    for (int m = 0; m < 3; m++) tot[m] = cb[2-m] + cr[2-m];
    em = 0;
    eb = tot[0];
    for (int m = 1; m < 3; m++) if (tot[m] < eb) begin em = m; eb = tot[m]; end

    send_triple({tag, "/cb"}, cb[0], cb[1], cb[2]);
    send_triple({tag, "/cr"}, cr[0], cr[1], cr[2]);
    chk({tag, "/valid_early"}, 32'(bus.mode_valid), 0);
    chk({tag, "/ready_cmp"},   32'(bus.sad_ready),  0);

    stat_clear = clr;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;
    if (clr) exp_cnt = '{0, 0, 0};
    else if (exp_cnt[em] < CNT_MAX) exp_cnt[em]++;

    chk({tag, "/valid"}, 32'(bus.mode_valid), 1);
    chk({tag, "/mode"},  32'(bus.mode_out),   em);
    chk({tag, "/best"},  32'(bus.best_sad),   eb);
    chk_counts(tag);

    for (int i = 0; i < hold; i++) begin
      bus.sad_valid = 1'b1;
      for (int k = 0; k < 3; k++) bus.sads[k] = SW'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      chk({tag, "/hold_valid"}, 32'(bus.mode_valid), 1);
      chk({tag, "/hold_mode"},  32'(bus.mode_out),   em);
      chk({tag, "/hold_best"},  32'(bus.best_sad),   eb);
      chk({tag, "/hold_rdy"},   32'(bus.sad_ready),  0);
      chk_counts({tag, "/hold"});
    end
    bus.sad_valid  = 1'b0;
    bus.mode_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mode_ready = 1'b0;
    chk({tag, "/valid_drop"}, 32'(bus.mode_valid), 0);
    chk({tag, "/ready_back"}, 32'(bus.sad_ready),  1);
  endtask

  task automatic v_winner();
    cb = '{$urandom_range(0, 20), $urandom_range(100, 255), $urandom_range(100, 255)};
    cr = '{$urandom_range(0, 20), $urandom_range(100, 255), $urandom_range(100, 255)};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_cnt        = '{0, 0, 0};
    bus.sad_valid  = 1'b0;
    bus.mode_ready = 1'b0;
    for (int k = 0; k < 3; k++) bus.sads[k] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst/sad_ready",  32'(bus.sad_ready),  1);
    chk("rst/mode_valid", 32'(bus.mode_valid), 0);
    chk("rst/mode_out",   32'(bus.mode_out),   0);
    chk("rst/best_sad",   32'(bus.best_sad),   0);
    chk_counts("rst");
    reset = 1'b0;

    cb = '{10, 20, 30};  cr = '{5, 5, 5};    run_pair("basic", 0, 1'b0);
    cb = '{40, 40, 40};  cr = '{0, 0, 0};    run_pair("tie_dc", 0, 1'b0);
    cb = '{40, 30, 50};  cr = '{0, 10, 0};   run_pair("tie_h", 0, 1'b0);
    cb = '{255, 255, 255}; cr = '{255, 255, 255}; run_pair("max", 0, 1'b0);
    v_winner();                              run_pair("bp", 5, 1'b0);

    // Reset with a Cb triple already accumulated
    send_triple("midrst/cb", 200, 200, 200);
    reset = 1'b1;
    #2;
    chk("midrst/sad_ready",  32'(bus.sad_ready),  1);
    chk("midrst/mode_valid", 32'(bus.mode_valid), 0);
    exp_cnt = '{0, 0, 0};
    chk_counts("midrst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    cb = '{1, 2, 3};  cr = '{1, 2, 3};       run_pair("after_rst", 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < 3; k++) begin
        cb[k] = (i % 2 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3);
        cr[k] = (i % 2 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3);
      end
      run_pair("rand", $urandom_range(0, 2), 1'b0);
    end

    // Saturation: 17 V wins after a fresh reset, then clear coinciding with an 18th
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_cnt = '{0, 0, 0};
    for (int i = 0; i < 17; i++) begin
      v_winner();
      run_pair("sat", 0, 1'b0);
    end
    chk("sat/cnt_v_final", 32'(cnt_v), CNT_MAX);
    v_winner();
    run_pair("sat_clr", 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
